// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register pending counters for long-latency writes, RAW/full stall generation.
// Optional write-through bypass of the completing writeback: define HAZARD_SCOREBOARD_WB_BYPASS_EN.
module hazard_scoreboard #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_rs_idx,
    input  logic [NUM_SRC-1:0]       id_rs_used,
    input  logic [REG_W-1:0]         id_rd,
    input  logic                     id_long_lat,
    input  logic                     issue,
    input  logic                     wb_valid,
    input  logic [REG_W-1:0]         wb_rd,
    input  logic                     kill_valid,
    input  logic [REG_W-1:0]         kill_rd,
    output logic                     stall_pipeline,
    output logic [1:0]               stall_cause,
    output logic [2**REG_W-1:0]      pending_mask,
    output logic                     sb_error,
    output logic [STAT_W-1:0]        stall_cycles
);
    localparam int NREG = 2**REG_W;

    logic [NREG-1:0][CNT_W-1:0] count;
    logic [NREG-1:0][CNT_W-1:0] count_nxt;
    logic [NREG-1:0]            mask_nxt;
    logic [NREG-1:0]            uf;
    logic [NUM_SRC-1:0]         raw_hit;
    logic                       full_hit;
    logic                       eff_issue;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + STAT_W'(1) : v;
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_W-1:0] idx;
        logic [CNT_W-1:0] cnt;
        logic             byp;
        assign idx = id_rs_idx[i*REG_W +: REG_W];
        assign cnt = count[idx];
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
        // Write-through regfile: the last outstanding write lands this cycle.
        assign byp = wb_valid & (wb_rd == idx) & (cnt == CNT_W'(1));
`else
        assign byp = 1'b0;
`endif
        assign raw_hit[i] = id_valid & id_rs_used[i] & (idx != '0) & (cnt != '0) & ~byp;
    end

    assign full_hit       = id_valid & id_long_lat & (id_rd != '0) & (&count[id_rd]);
    assign stall_pipeline = (|raw_hit) | full_hit;
    assign eff_issue      = issue & id_valid & ~stall_pipeline;

    always_comb begin
        stall_cause = 2'd0;
        if (|raw_hit)
            stall_cause = 2'd1;
        else if (full_hit)
            stall_cause = 2'd2;
    end

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign count_nxt[r] = '0;
            assign uf[r]        = 1'b0;
            assign mask_nxt[r]  = 1'b0;
        end else begin : g_cnt
            logic           inc, dec_wb, dec_kill;
            logic [CNT_W:0] up, dn;
            assign inc      = eff_issue & id_long_lat & (id_rd == REG_W'(r));
            assign dec_wb   = wb_valid & (wb_rd == REG_W'(r));
            assign dec_kill = kill_valid & (kill_rd == REG_W'(r));
            assign up       = {1'b0, count[r]} + (CNT_W+1)'(inc);
            assign dn       = (CNT_W+1)'(dec_wb) + (CNT_W+1)'(dec_kill);
            // More retirements than outstanding writes: clamp and flag.
            assign uf[r]        = (dn > up);
            assign count_nxt[r] = uf[r] ? '0 : CNT_W'(up - dn);
            assign mask_nxt[r]  = (count_nxt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count        <= '0;
            pending_mask <= '0;
            sb_error     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            count        <= count_nxt;
            pending_mask <= mask_nxt;
            sb_error     <= sb_error | (|uf);
            stall_cycles <= sat_inc(stall_cycles, stall_pipeline);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a per-cycle reference model and literal spot checks.
module tb_hazard_scoreboard;
    localparam int STAT_W = 4;
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [9:0]  id_rs_idx = '0;
    logic [1:0]  id_rs_used = '0;
    logic [4:0]  id_rd = '0;
    logic        id_long_lat = 1'b0;
    logic        issue = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        kill_valid = 1'b0;
    logic [4:0]  kill_rd = '0;
    logic        stall_pipeline;
    logic [1:0]  stall_cause;
    logic [31:0] pending_mask;
    logic        sb_error;
    logic [STAT_W-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int mcnt[32];
    bit merr = 1'b0;
    int mstall = 0;

    hazard_scoreboard #(.REG_W(5), .NUM_SRC(2), .CNT_W(2), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_idx(id_rs_idx),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_long_lat(id_long_lat), .issue(issue),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .kill_valid(kill_valid), .kill_rd(kill_rd),
        .stall_pipeline(stall_pipeline), .stall_cause(stall_cause), .pending_mask(pending_mask),
        .sb_error(sb_error), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: stall rules evaluated over integer counters.
    function automatic void m_eval(output bit stall, output logic [1:0] cause);
        bit raw = 1'b0;
        bit full;
        int idx;
        for (int i = 0; i < 2; i++) begin
            idx = int'(id_rs_idx[i*5 +: 5]);
            if (id_valid && id_rs_used[i] && idx != 0 && mcnt[idx] != 0 &&
                !(BYP && mcnt[idx] == 1 && wb_valid && int'(wb_rd) == idx))
                raw = 1'b1;
        end
        full  = id_valid && id_long_lat && id_rd != 0 && mcnt[id_rd] == 3;
        stall = raw | full;
        cause = raw ? 2'd1 : (full ? 2'd2 : 2'd0);
    endfunction

    always @(posedge clk) begin : model
        bit s;
        logic [1:0] c;
        int n;
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
            merr   = 1'b0;
            mstall = 0;
        end else begin
            m_eval(s, c);
            for (int r = 1; r < 32; r++) begin
                n = mcnt[r];
                if (issue && id_valid && !s && id_long_lat && int'(id_rd) == r) n++;
                if (wb_valid && int'(wb_rd) == r) n--;
                if (kill_valid && int'(kill_rd) == r) n--;
                if (n < 0) begin
                    n = 0;
                    merr = 1'b1;
                end
                mcnt[r] = n;
            end
            if (s && mstall < 15) mstall++;
        end
    end

    always @(negedge clk) begin : compare
        bit s;
        logic [1:0] c;
        logic [31:0] m;
        if (chk_en) begin
            m_eval(s, c);
            m = '0;
            for (int r = 0; r < 32; r++) m[r] = (mcnt[r] != 0);
            chk("stall_pipeline", stall_pipeline, s);
            chk("stall_cause", stall_cause, c);
            chk("pending_mask", pending_mask, m);
            chk("sb_error", sb_error, merr);
            chk("stall_cycles", stall_cycles, mstall);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs_idx = '0; id_rs_used = '0; id_rd = '0; id_long_lat = 0;
        issue = 0; wb_valid = 0; wb_rd = '0; kill_valid = 0; kill_rd = '0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        idle();
        id_valid = 1; id_long_lat = 1; id_rd = rd; issue = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst_n = 0;
        cyc(); cyc();
        rst_n = 1;
        chk_en = 1;
        @(negedge clk);
        chk("rst_mask", pending_mask, 32'h0);
        chk("rst_stall", stall_pipeline, 1'b0);
        chk("rst_cycles", stall_cycles, 0);
        chk("rst_err", sb_error, 1'b0);

        // Reset with a dirty counter, and a same-cycle issue overridden by reset
        issue_long(5'd5); cyc(); idle();
        @(negedge clk);
        chk("dirty_mask", pending_mask, 32'h20);
        issue_long(5'd6); rst_n = 0; cyc();
        rst_n = 1; idle();
        @(negedge clk);
        chk("rst2_mask", pending_mask, 32'h0);
        chk("rst2_stall", stall_pipeline, 1'b0);
        chk("rst2_cycles", stall_cycles, 0);

        // Load-use on x5
        issue_long(5'd5); cyc();
        idle(); id_valid = 1; id_rs_idx = {5'd0, 5'd5}; id_rs_used = 2'b01; issue = 1;
        @(negedge clk);
        chk("lu_stall", stall_pipeline, 1'b1);
        chk("lu_cause", stall_cause, 2'd1);
        cyc();
        wb_valid = 1; wb_rd = 5'd5;
        @(negedge clk);
        chk("lu_wb_stall", stall_pipeline, BYP ? 1'b0 : 1'b1);
        cyc();
        wb_valid = 0;
        @(negedge clk);
        chk("lu_after_stall", stall_pipeline, 1'b0);
        chk("lu_cycles", stall_cycles, BYP ? 1 : 2);
        cyc(); idle();

        // x0 is never pending; an unused source never stalls
        issue_long(5'd0); cyc();
        issue_long(5'd7); cyc();
        idle(); id_valid = 1; id_rs_idx = {5'd7, 5'd0}; id_rs_used = 2'b01; issue = 1;
        @(negedge clk);
        chk("x0_stall", stall_pipeline, 1'b0);
        chk("x0_mask", pending_mask, 32'h80);
        cyc();
        idle(); wb_valid = 1; wb_rd = 5'd7; cyc(); idle();

        // Counter saturation on x9
        repeat (3) begin issue_long(5'd9); cyc(); end
        @(negedge clk);
        chk("sat_stall", stall_pipeline, 1'b1);
        chk("sat_cause", stall_cause, 2'd2);
        cyc();
        wb_valid = 1; wb_rd = 5'd9; cyc();
        wb_valid = 0;
        @(negedge clk);
        chk("sat_issue", stall_pipeline, 1'b0);
        cyc(); idle();
        @(negedge clk);
        chk("sat_mask", pending_mask, 32'h200);
        repeat (3) begin idle(); wb_valid = 1; wb_rd = 5'd9; cyc(); end
        idle();

        // Simultaneous inc/dec, then double retire underflow on x4
        issue_long(5'd4); cyc();
        issue_long(5'd4); wb_valid = 1; wb_rd = 5'd4; cyc();
        idle();
        @(negedge clk);
        chk("cancel_mask", pending_mask, 32'h10);
        wb_valid = 1; wb_rd = 5'd4; kill_valid = 1; kill_rd = 5'd4; cyc();
        idle();
        @(negedge clk);
        chk("uf_err", sb_error, 1'b1);
        chk("uf_mask", pending_mask, 32'h0);
        cyc(); cyc();
        @(negedge clk);
        chk("uf_sticky", sb_error, 1'b1);

        // Stall-cycle counter and saturation
        rst_n = 0; cyc(); rst_n = 1;
        @(negedge clk);
        chk("rst3_err", sb_error, 1'b0);
        issue_long(5'd3); cyc();
        idle(); id_valid = 1; id_rs_idx = {5'd3, 5'd0}; id_rs_used = 2'b10; issue = 1;
        repeat (10) cyc();
        @(negedge clk);
        chk("cyc10", stall_cycles, 10);
        repeat (10) cyc();
        @(negedge clk);
        chk("cyc_sat", stall_cycles, 15);
        wb_valid = 1; wb_rd = 5'd3; cyc();
        idle(); cyc(); cyc();

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use hazard check in the decode stage.
- Tracks in-flight long-latency register writes (loads, mul/div) with a per-register pending counter, so stall decisions no longer depend on those ops being exactly one stage ahead.
- Raises stall_pipeline to the IF/ID hold logic while any used source of the ID instruction has an unresolved producer.
- Also reports stall cause, pending mask, sticky error and a stall-cycle counter.

Parameters:
- REG_W, 5: register index width; the scoreboard has 2**REG_W entries.
- NUM_SRC, 2: number of source operands checked per ID instruction.
- CNT_W, 2: per-register pending counter width; max in-flight writes per register is 2**CNT_W-1.
- STAT_W, 32: stall-cycle counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs_idx  in  NUM_SRC*REG_W  source indices; src i at bits [i*REG_W +: REG_W]
- id_rs_used  in  NUM_SRC  per-source "operand read" flag
- id_rd  in  REG_W  destination of ID instruction
- id_long_lat  in  1  ID instruction writes rd through a long-latency path
- issue  in  1  ID->EX advance this cycle (pipeline control, excludes downstream stalls)
- wb_valid  in  1  long-latency writeback completes this cycle
- wb_rd  in  REG_W  destination of that writeback
- kill_valid  in  1  squashed in-flight long-latency op (flush)
- kill_rd  in  REG_W  destination of squashed op
- stall_pipeline  out  1  hold IF/ID, inject bubble into EX
- stall_cause  out  2  0 none, 1 RAW, 2 counter full, 3 reserved
- pending_mask  out  2**REG_W  bit r set iff count[r] != 0
- sb_error  out  1  sticky underflow flag
- stall_cycles  out  STAT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst_n low at posedge): all counters 0, sb_error 0, stall_cycles 0. Consequently stall_pipeline 0, stall_cause 0, pending_mask 0. Reset overrides same-cycle issue/wb/kill.
- Register 0 is never pending: inc/dec targeting index 0 is ignored.
- raw_hit[i] = id_valid & id_rs_used[i] & (idx_i != 0) & count[idx_i] != 0.
- full_hit = id_valid & id_long_lat & (id_rd != 0) & count[id_rd] == max.
- stall_pipeline = |raw_hit | full_hit. It is combinational from registered counters and current inputs, with zero-cycle latency.
- stall_cause = 1 if any raw_hit (RAW has priority), else 2 if full_hit, else 0.
- eff_issue = issue & id_valid & ~stall_pipeline. Issue while stalled is ignored.
- Per register r, next count = count + inc - dec_wb - dec_kill:
  - inc = eff_issue & id_long_lat & id_rd == r
  - dec_wb = wb_valid & wb_rd == r
  - dec_kill = kill_valid & kill_rd == r
- Same-cycle inc and dec on r cancel, net zero.
- Underflow: if the decrements exceed count + inc, the counter clamps to 0 and sb_error sets. sb_error holds until reset.
- pending_mask is registered state, valid the cycle after the update.
- stall_cycles increments each cycle stall_pipeline is high and saturates at all-ones.
- Mid-operation reset discards all pending state. The pipeline must flush alongside.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_WB_BYPASS_EN.
- Defined: a source whose count is 1 and which matches wb_rd with wb_valid this cycle is not a RAW hit, because the regfile is write-through. The same bypass does not apply through kill.
- Undefined: that source stalls one more cycle, until the counter reads 0.
- stall_cause and stall_cycles follow the resulting stall_pipeline.

Test Plan:
- Reset with counters dirty: load x5 issued, then rst_n=0 for one cycle -> pending_mask=0, stall_pipeline=0, stall_cycles=0.
- Load-use: issue long-lat rd=5, next cycle ID reads rs1=5 -> stall_pipeline=1, cause=1. Held until wb_valid wb_rd=5. Bypass on: stall drops the wb cycle (1 stall cycle total for 1-cycle load latency). Bypass off: stall drops the cycle after, 2 stall cycles.
- x0 and unused source: issue long-lat rd=0, then ID rs1=0, and rs2=7 with id_rs_used[1]=0 while x7 pending -> no stall, pending_mask[0]=0.
- Saturation with CNT_W=2: three long-lat issues to rd=9 -> count 3; fourth issue -> stall_pipeline=1, cause=2, count stays 3. One wb to 9 -> fourth issues, count 3.
- Simultaneous events: count[4]=1, same cycle issue long-lat rd=4 and wb_rd=4 -> count[4]=1. Then wb and kill both to 4 -> count 0, sb_error=1 and stays 1.
- Stall counter: hold a RAW stall for 10 cycles -> stall_cycles=10. With STAT_W=4 and 20 cycles -> stalls saturate at 15.
